store_byte_unit: RTL and testbench
==================================

STORE_BYTE_UNIT -- requirements
Module: store_byte_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of the byte address and of mem_addr.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port MemWrite  input  1  store request from the controller, held until Done.
REQ-005 SHALL have port StoreByte  input  1  1 = STRB (byte store), 0 = STR (word store).
REQ-006 SHALL have port Addr  input  ADDR_W  byte address (ALUResult).
REQ-007 SHALL have port WriteData  input  32  store data (register rd2); only bits 7:0 are used for a byte store.
REQ-008 SHALL have port Stall  output  1  freezes PC and register-file write while a store is in progress.
REQ-009 SHALL have port Done  output  1  one-cycle pulse when the store is complete.
REQ-010 SHALL have port mem_req  output  1  word-memory request.
REQ-011 SHALL have port mem_we  output  1  1 = write, 0 = read.
REQ-012 SHALL have port mem_addr  output  ADDR_W  word-aligned address {Addr[ADDR_W-1:2],2'b00}.
REQ-013 SHALL have port mem_wdata  output  32  write word.
REQ-014 SHALL have port mem_rdata  input  32  read word, valid when mem_ack is high.
REQ-015 SHALL have port mem_ack  input  1  completes the current request.

Function
REQ-016 SHALL implement the states IDLE, READ, WRITE and DONE.
REQ-017 In IDLE with MemWrite=1, SHALL latch Addr, WriteData and StoreByte, then go to READ if StoreByte=1, otherwise to WRITE.
REQ-018 In READ, SHALL drive mem_req=1 and mem_we=0; on mem_ack=1, SHALL capture mem_rdata with the byte lane selected by Addr[1:0] replaced by WriteData[7:0], then go to WRITE.
REQ-019 SHALL map byte lanes as 0 -> bits 7:0, 1 -> 15:8, 2 -> 23:16, 3 -> 31:24, matching the load-byte read path; all other lanes SHALL be preserved bit-exact.
REQ-020 In WRITE, SHALL drive mem_req=1, mem_we=1, and mem_wdata equal to the merged word (byte store) or the latched WriteData (word store); on mem_ack=1, SHALL go to DONE.
REQ-021 In DONE, SHALL assert Done=1 and Stall=0, ignore MemWrite, and go to IDLE on the next cycle.
REQ-022 SHALL drive Stall=1 when (IDLE and MemWrite=1) or the state is READ or WRITE.
REQ-023 SHALL derive mem_req and mem_we only from the state, with no combinational path from mem_ack.
REQ-024 SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack; mem_ack in the same cycle mem_req first rises SHALL be accepted.
REQ-025 SHALL ignore mem_ack while in IDLE or DONE.
REQ-026 Latency with zero-wait memory: a word store SHALL give Stall for 2 cycles and Done in cycle 3; a byte store SHALL give Stall for 3 cycles and Done in cycle 4.
REQ-027 Latched inputs SHALL be used throughout; changes to Addr or WriteData after acceptance SHALL have no effect.

Reset
REQ-028 On reset=0 at a clock edge, SHALL set the state to IDLE and set mem_req, mem_we, Done and mem_wdata to 0, and clear the latched registers.
REQ-029 Reset asserted in READ or WRITE SHALL drop mem_req on the next cycle, with no write issued afterwards.
REQ-030 Stall SHALL be 0 during reset regardless of MemWrite.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE=2'b00, READ=2'b01, WRITE=2'b10, DONE=2'b11) and the byte-lane constants.
REQ-032 Lane insertion SHALL be a combinational sub-module byte_merge, with inputs word[31:0], byte[7:0] and lane[1:0] and output merged[31:0].

Verification
REQ-033 Word store, zero-wait: Addr=0x104, WriteData=0xDEADBEEF -> one write, mem_addr=0x104, mem_wdata=0xDEADBEEF, Done in cycle 3.
REQ-034 Byte store to lane 2: Addr=0x102, WriteData=0x000000A5, mem_rdata=0x11223344 -> read, then write of 0x11A53344 to 0x100.
REQ-035 Lanes 0, 1 and 3 with mem_rdata=0xFFFFFFFF and byte 0x00 -> 0xFFFFFF00, 0xFFFF00FF and 0x00FFFFFF respectively.
REQ-036 Wait states: mem_ack delayed 3 cycles in READ and 2 cycles in WRITE -> outputs held stable, Stall high throughout, exactly one Done.
REQ-037 Reset mid-WRITE: reset=0 while mem_req=1 -> next cycle mem_req=0, state IDLE, no Done.
REQ-038 Back-to-back stores: MemWrite held through DONE -> a second store starts only from the IDLE cycle, and no duplicate write occurs.

Source files
------------

// File: rtl/store_byte_unit_pkg.sv
// Shared encodings for the store-byte unit: FSM state values, byte-lane
// indices and a small state-decode helper.
package store_byte_unit_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_READ  = 2'b01;
  localparam logic [1:0] ST_WRITE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // Lane n covers bits [8n+7:8n], matching the load-byte read path.
  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  function automatic logic is_mem_state(input logic [1:0] st);
    return (st == ST_READ) || (st == ST_WRITE);
  endfunction

endpackage

// File: rtl/byte_merge.sv
// Combinational byte-lane insertion: replaces one lane of a word with a byte,
// leaving the other three lanes untouched.
module byte_merge
  import store_byte_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [7:0]  data_byte,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  // Lane select; unselected bits pass straight through from word.
  always_comb begin
    merged = word;
    case (lane)
      LANE_0:  merged[7:0]   = data_byte;
      LANE_1:  merged[15:8]  = data_byte;
      LANE_2:  merged[23:16] = data_byte;
      LANE_3:  merged[31:24] = data_byte;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/store_byte_unit.sv
// Store unit for STR/STRB: word stores go straight to memory, byte stores do a
// read-modify-write of the containing word, stalling the core while busy.
module store_byte_unit
  import store_byte_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic              StoreByte,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WriteData,
  output logic              Stall,
  output logic              Done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sb_q, sb_d;
  // Holds the latched store data, later overwritten by the merged word on a byte store.
  logic [31:0]       wword_q, wword_d;
  logic [31:0]       merged_word;

  byte_merge u_merge (
    .word      (mem_rdata),
    .data_byte (wword_q[7:0]),
    .lane      (addr_q[1:0]),
    .merged    (merged_word)
  );

  // Next-state and datapath update; mem_ack only matters in READ and WRITE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sb_d    = sb_q;
    wword_d = wword_q;
    case (state_q)
      ST_IDLE: begin
        if (MemWrite) begin
          addr_d  = Addr;
          sb_d    = StoreByte;
          wword_d = WriteData;
          state_d = StoreByte ? ST_READ : ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          wword_d = sb_q ? merged_word : wword_q;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-operand registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      sb_q    <= 1'b0;
      wword_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sb_q    <= sb_d;
      wword_q <= wword_d;
    end
  end

  // Memory handshake is a pure decode of the state register.
  assign mem_req   = is_mem_state(state_q);
  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wword_q;
  assign Done      = (state_q == ST_DONE);
  assign Stall     = reset & (((state_q == ST_IDLE) & MemWrite) | is_mem_state(state_q));

endmodule

// File: tb/tb_store_byte_unit.sv
// Self-checking bench for store_byte_unit: a wait-state memory responder
// scores every write against a queue of expected (address, word) pairs.
module tb_store_byte_unit;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        StoreByte;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        Stall;
  logic        Done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  int          rd_wait = 0;
  int          wr_wait = 0;
  logic        spur_ack = 1'b0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          done_total = 0;

  store_byte_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .StoreByte (StoreByte),
    .Addr      (Addr),
    .WriteData (WriteData),
    .Stall     (Stall),
    .Done      (Done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge_model(input logic [31:0] w, input logic [7:0] b,
                                              input logic [1:0] l);
    logic [31:0] r;
    r = w;
    r[int'(l)*8 +: 8] = b;
    return r;
  endfunction

  // Memory responder: decides mem_ack mid-cycle, scores writes, checks request stability.
  initial begin : responder
    int          cnt;
    int          need;
    logic        pend;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    cnt = 0;
    pend = 1'b0;
    p_addr = 32'h0; p_wdata = 32'h0; p_we = 1'b0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (Done) done_total++;
      if (mem_req && reset) begin
        if (pend) begin
          check("hold_addr", mem_addr, p_addr);
          check("hold_wdata", mem_wdata, p_wdata);
          check("hold_we", mem_we, p_we);
        end
        need = mem_we ? wr_wait : rd_wait;
        if (cnt >= need) begin
          mem_ack = 1'b1;
          cnt = 0;
          pend = 1'b0;
          if (mem_we) begin
            wr_cnt++;
            check("wr_expected", exp_addr_q.size() > 0, 1'b1);
            if (exp_addr_q.size() > 0) begin
              check("wr_addr", mem_addr, exp_addr_q.pop_front());
              check("wr_data", mem_wdata, exp_data_q.pop_front());
            end
          end else begin
            rd_cnt++;
          end
        end else begin
          mem_ack = 1'b0;
          cnt++;
          pend = 1'b1;
          p_addr = mem_addr; p_wdata = mem_wdata; p_we = mem_we;
        end
      end else begin
        mem_ack = spur_ack;
        cnt = 0;
        pend = 1'b0;
      end
    end
  end

  task automatic do_store(input logic sb, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int rw, input int ww);
    logic [31:0] exp_w;
    int stall_n, done_cyc, rd0, wr0, d0, exp_stall;
    exp_w = sb ? merge_model(rdata, wdata[7:0], addr[1:0]) : wdata;
    exp_addr_q.push_back({addr[31:2], 2'b00});
    exp_data_q.push_back(exp_w);
    rd_wait = rw; wr_wait = ww; mem_rdata = rdata;
    rd0 = rd_cnt; wr0 = wr_cnt; d0 = done_total;
    stall_n = 0; done_cyc = 0;
    exp_stall = sb ? 3 + rw + ww : 2 + ww;
    @(posedge clk); #1;
    MemWrite = 1'b1; StoreByte = sb; Addr = addr; WriteData = wdata;
    for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (Stall) stall_n++;
      if (Done) begin
        done_cyc = cyc;
        MemWrite = 1'b0;
      end
      @(posedge clk); #1;
      // Scramble operands once accepted; the unit must use its latched copies.
      if (cyc == 1) begin
        Addr = ~addr; WriteData = ~wdata; StoreByte = ~sb;
      end
    end
    MemWrite = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (Stall) stall_n++;
    end
    check("stall_cycles", stall_n, exp_stall);
    check("done_cycle", done_cyc, exp_stall + 1);
    check("done_count", done_total - d0, 1);
    check("read_count", rd_cnt - rd0, {31'd0, sb});
    check("write_count", wr_cnt - wr0, 1);
    check("sb_empty", exp_addr_q.size(), 0);
  endtask

  initial begin : main
    int wr0, d0, found;
    reset = 1'b0; MemWrite = 1'b1; StoreByte = 1'b0;
    Addr = 32'h0; WriteData = 32'h0; mem_rdata = 32'h0;

    // Reset with MemWrite high: no stall, outputs cleared.
    @(posedge clk); @(negedge clk);
    check("rst_stall", Stall, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    MemWrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    do_store(1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0, 0);
    do_store(1'b1, 32'h0000_0102, 32'h0000_00A5, 32'h1122_3344, 0, 0);
    do_store(1'b1, 32'h0000_0200, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0);
    do_store(1'b1, 32'h0000_0201, 32'h1234_5600, 32'hFFFF_FFFF, 0, 0);
    do_store(1'b1, 32'h0000_0203, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0, 0);
    do_store(1'b1, 32'h0000_0102, 32'h0000_00A5, 32'h1122_3344, 3, 2);
    do_store(1'b0, 32'h0000_0ABC, 32'h0BAD_CAFE, 32'h0, 0, 4);
    for (int i = 0; i < 4; i++)
      do_store(1'b1, $urandom, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));

    // Acks while idle are ignored.
    spur_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spur_req", mem_req, 1'b0);
      check("spur_done", Done, 1'b0);
    end
    spur_ack = 1'b0;

    // Reset asserted mid-WRITE: request dropped, no write, no Done.
    wr0 = wr_cnt; d0 = done_total; wr_wait = 1000;
    @(posedge clk); #1;
    MemWrite = 1'b1; StoreByte = 1'b0; Addr = 32'h400; WriteData = 32'hCAFE_F00D;
    @(negedge clk); @(negedge clk);
    check("rstw_pre_req", mem_req, 1'b1);
    check("rstw_pre_we", mem_we, 1'b1);
    reset = 1'b0;
    #1;
    check("rstw_stall", Stall, 1'b0);
    @(negedge clk);
    check("rstw_req", mem_req, 1'b0);
    check("rstw_done", Done, 1'b0);
    check("rstw_wdata", mem_wdata, 32'h0);
    MemWrite = 1'b0; reset = 1'b1; wr_wait = 0;
    repeat (4) @(negedge clk);
    check("rstw_no_write", wr_cnt - wr0, 0);
    check("rstw_no_done", done_total - d0, 0);

    // Back-to-back: MemWrite held through DONE; second store starts from IDLE.
    wr0 = wr_cnt; d0 = done_total;
    mem_rdata = 32'hAABB_CCDD; rd_wait = 0; wr_wait = 0;
    exp_addr_q.push_back(32'h300); exp_data_q.push_back(32'h0102_0304);
    exp_addr_q.push_back(32'h304); exp_data_q.push_back(32'hAABB_77DD);
    @(posedge clk); #1;
    MemWrite = 1'b1; StoreByte = 1'b0; Addr = 32'h300; WriteData = 32'h0102_0304;
    found = 0;
    for (int cyc = 0; cyc < 20 && found == 0; cyc++) begin
      @(negedge clk);
      if (Done) begin
        found = 1;
        check("b2b_done_stall", Stall, 1'b0);
        check("b2b_done_req", mem_req, 1'b0);
        StoreByte = 1'b1; Addr = 32'h305; WriteData = 32'h0000_0077;
      end
    end
    check("b2b_first_done", found, 1);
    @(negedge clk);
    check("b2b_idle_req", mem_req, 1'b0);
    check("b2b_idle_stall", Stall, 1'b1);
    found = 0;
    for (int cyc = 0; cyc < 20 && found == 0; cyc++) begin
      @(negedge clk);
      if (Done) begin
        found = 1;
        MemWrite = 1'b0;
      end
    end
    check("b2b_second_done", found, 1);
    MemWrite = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_writes", wr_cnt - wr0, 2);
    check("b2b_dones", done_total - d0, 2);
    check("b2b_sb_empty", exp_addr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
